// File: rtl/prog_ram_pkg.sv
// prog_ram_pkg: shared types and default sizing for the program/data RAM.
//   prog_ram_state_e : loader FSM states (IDLE, LOAD, FULL)
//   DEF_DATA_W       : default word width
//   DEF_ADDR_W       : default address width (DEPTH = 2**ADDR_W)
//   parity8          : even-parity helper used by the default 8-bit build checks
package prog_ram_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    FULL = 2'd2
  } prog_ram_state_e;

  // Even parity bit of a default-width word.
  function automatic logic parity8(input logic [DEF_DATA_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/prog_ram_loader.sv
// prog_ram_loader: program-load sequencer for prog_ram.
// Detects prog_mode edges, runs the IDLE/LOAD/FULL FSM and produces the loader
// write strobe/address that the top level feeds into the memory array.
// Ports:
//   clk, reset    clock, asynchronous active-low reset
//   prog_mode     level, high = program-load mode
//   load_valid    loader beat valid
//   load_ready    loader may transfer this cycle (combinational)
//   load_ptr      next load address
//   load_full     all DEPTH words loaded since the last rising edge
//   load_we       loader write strobe (accepted beat)
//   load_addr     loader write address
//   cpu_wr_allow  CPU writes are permitted this cycle
module prog_ram_loader
  import prog_ram_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_mode,
  input  logic              load_valid,
  output logic              load_ready,
  output logic [ADDR_W-1:0] load_ptr,
  output logic              load_full,
  output logic              load_we,
  output logic [ADDR_W-1:0] load_addr,
  output logic              cpu_wr_allow
);

  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};

  prog_ram_state_e   state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              full_q, full_d;
  logic              prog_prev_q;
  logic              prog_rise, prog_fall;
  logic              accept;

  // prog_prev_q resets to 0, so prog_mode held high through reset release
  // is seen as a rising edge on the first clock.
  assign prog_rise = prog_mode & ~prog_prev_q;
  assign prog_fall = ~prog_mode & prog_prev_q;

  // Gating with prog_mode drops a beat offered in the same cycle prog_mode falls.
  assign load_ready   = (state_q == LOAD) && prog_mode;
  assign accept       = load_valid && load_ready;
  assign load_we      = accept;
  assign load_addr    = ptr_q;
  assign cpu_wr_allow = (state_q == IDLE) && !prog_mode;

  assign load_ptr  = ptr_q;
  assign load_full = full_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    full_d  = full_q;
    unique case (state_q)
      IDLE: begin
        if (prog_rise) begin
          state_d = LOAD;
          ptr_d   = '0;
          full_d  = 1'b0;
        end
      end
      LOAD: begin
        if (prog_fall) begin
          state_d = IDLE;
        end else if (accept) begin
          // Pointer wraps to 0 naturally after the last word.
          ptr_d = ptr_q + 1'b1;
          if (ptr_q == LastAddr) begin
            state_d = FULL;
            full_d  = 1'b1;
          end
        end
      end
      FULL: begin
        // load_full deliberately holds through the return to IDLE.
        if (prog_fall) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      full_q      <= 1'b0;
      prog_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      full_q      <= full_d;
      prog_prev_q <= prog_mode;
    end
  end

endmodule

// File: rtl/prog_ram.sv
// prog_ram: single-port program/data RAM for the 8-bit CPU core.
// CPU side has a registered synchronous read (read-first) and a write strobe
// honoured only while idle; loader side fills memory from address 0 upward via
// a valid/ready stream while prog_mode is high.
// Optional feature macro: PROG_RAM_PARITY_EN adds a stored even-parity bit per
// word and a registered parity_err check; without it parity_err is tied 0.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   prog_mode    level, high = program-load mode
//   address      CPU read/write address
//   w_en, w_data CPU write strobe and data
//   r_data       registered read data (1-cycle latency)
//   load_valid, load_data, load_ready   loader stream
//   load_ptr     next load address
//   load_full    all DEPTH words loaded
//   parity_err   read parity mismatch (registered with r_data)
module prog_ram
  import prog_ram_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_mode,
  input  logic [ADDR_W-1:0] address,
  input  logic              w_en,
  input  logic [DATA_W-1:0] w_data,
  output logic [DATA_W-1:0] r_data,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic [ADDR_W-1:0] load_ptr,
  output logic              load_full,
  output logic              parity_err
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic              cpu_wr_allow;
  logic              cpu_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] mem [DEPTH];

  prog_ram_loader #(
    .ADDR_W (ADDR_W)
  ) u_loader (
    .clk          (clk),
    .reset        (reset),
    .prog_mode    (prog_mode),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_ptr     (load_ptr),
    .load_full    (load_full),
    .load_we      (load_we),
    .load_addr    (load_addr),
    .cpu_wr_allow (cpu_wr_allow)
  );

  assign cpu_we = w_en && cpu_wr_allow;

  // The two write sources are mutually exclusive (CPU writes need IDLE, loader
  // writes need LOAD); the loader still takes priority in the mux.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = address;
    mem_wdata = w_data;
    if (load_we) begin
      mem_we    = 1'b1;
      mem_waddr = load_addr;
      mem_wdata = load_data;
    end else if (cpu_we) begin
      mem_we = 1'b1;
    end
  end

  // Array is intentionally not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  // Read-first: the registered read sees the pre-write contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_data <= '0;
    end else begin
      r_data <= mem[address];
    end
  end

`ifdef PROG_RAM_PARITY_EN
  logic par_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      par_mem[mem_waddr] <= ^mem_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      parity_err <= 1'b0;
    end else begin
      parity_err <= par_mem[address] != (^mem[address]);
    end
  end
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_ram.sv
// tb_prog_ram: scoreboard bench for prog_ram. A driver applies one cycle of
// stimulus at a time, advances a behavioural model of the RAM/loader and pushes
// the expected post-edge outputs; a monitor pops and compares after each edge.
module tb_prog_ram;

  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       prog_mode = 1'b0;
  logic [3:0] address = '0;
  logic       w_en = 1'b0;
  logic [7:0] w_data = '0;
  logic [7:0] r_data;
  logic       load_valid = 1'b0;
  logic [7:0] load_data = '0;
  logic       load_ready;
  logic [3:0] load_ptr;
  logic       load_full;
  logic       parity_err;

  always #5 clk = ~clk;

  prog_ram #(
    .DATA_W (8),
    .ADDR_W (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .prog_mode  (prog_mode),
    .address    (address),
    .w_en       (w_en),
    .w_data     (w_data),
    .r_data     (r_data),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .load_ptr   (load_ptr),
    .load_full  (load_full),
    .parity_err (parity_err)
  );

  typedef struct {
    bit         chk;   // expected read data is known
    logic [7:0] r;
    logic [3:0] ptr;
    bit         full;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Behavioural model: memory image, whether a load session is open, beats
  // taken in the session, sticky full flag, last sampled prog_mode.
  logic [7:0] m_mem   [DEPTH];
  bit         m_known [DEPTH];
  bit         m_session = 0;
  int         m_cnt = 0;
  bit         m_full = 0;
  bit         m_prev = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rn, input bit pm, input bit v, input logic [7:0] ld,
                       input bit we, input logic [3:0] a, input logic [7:0] wd);
    exp_t e;
    bit   rdy;
    bit   rise;
    bit   fall;
    @(posedge clk);
    #2;
    reset = rn; prog_mode = pm; load_valid = v; load_data = ld;
    w_en = we; address = a; w_data = wd;
    #1;
    rdy = rn && m_session && (m_cnt < DEPTH) && pm;
    check("load_ready", 32'(load_ready), 32'(rdy));
    if (!rn) begin
      m_session = 0; m_cnt = 0; m_full = 0; m_prev = 0;
      e.chk = 1; e.r = 8'h00; e.ptr = 4'h0; e.full = 0;
    end else begin
      e.chk = m_known[a];
      e.r   = m_mem[a];
      rise  = pm && !m_prev;
      fall  = !pm && m_prev;
      if (rdy && v) begin
        m_mem[m_cnt] = ld;
        m_known[m_cnt] = 1;
        m_cnt++;
        if (m_cnt == DEPTH) m_full = 1;
      end
      if (we && !m_session && !pm) begin
        m_mem[a] = wd;
        m_known[a] = 1;
      end
      if (rise) begin
        m_session = 1; m_cnt = 0; m_full = 0;
      end
      if (fall) m_session = 0;
      m_prev = pm;
      e.ptr  = 4'(m_cnt % DEPTH);
      e.full = m_full;
    end
    q.push_back(e);
  endtask

  task automatic idle(input logic [3:0] a);
    cycle(1, 0, 0, 8'h00, 0, a, 8'h00);
  endtask

  // Monitor: compares registered outputs just after each active edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        if (e.chk) begin
          check("r_data", 32'(r_data), 32'(e.r));
          check("parity_err", 32'(parity_err), 32'h0);
        end
        check("load_ptr", 32'(load_ptr), 32'(e.ptr));
        check("load_full", 32'(load_full), 32'(e.full));
      end
    end
  end

  initial begin
    bit         rn;
    bit         pm;
    bit         we;
    int         k;
    for (int i = 0; i < DEPTH; i++) m_known[i] = 0;

    // Reset with prog_mode low.
    repeat (3) cycle(0, 0, 0, 8'h00, 0, 4'h0, 8'h00);
    repeat (2) idle(4'h0);

    // Full 16-beat load with valid gaps, then extra beats while FULL.
    cycle(1, 1, 0, 8'h00, 0, 4'h0, 8'h00);
    for (int i = 0; i < 16; i++) begin
      cycle(1, 1, 1, 8'(8'h10 + i), 0, 4'(i), 8'h00);
      if (i % 3 == 0) cycle(1, 1, 0, 8'hEE, 0, 4'h0, 8'h00);
    end
    repeat (3) cycle(1, 1, 1, 8'hEE, 0, 4'h0, 8'h00);
    idle(4'h5);
    idle(4'h5);
    idle(4'h0);
    idle(4'hF);

    // Partial load; beat offered as prog_mode falls must be dropped.
    cycle(1, 1, 0, 8'h00, 0, 4'h0, 8'h00);
    for (int i = 0; i < 3; i++) cycle(1, 1, 1, 8'(8'hA0 + i), 0, 4'h0, 8'h00);
    cycle(1, 0, 1, 8'hFF, 0, 4'h3, 8'h00);
    idle(4'h3);
    idle(4'h2);

    // Idle write with same-cycle read, then read back; write ignored in prog_mode.
    cycle(1, 0, 0, 8'h00, 1, 4'h7, 8'h3C);
    idle(4'h7);
    cycle(1, 1, 0, 8'h00, 1, 4'h8, 8'h55);
    cycle(1, 1, 0, 8'h00, 1, 4'h8, 8'h56);
    idle(4'h8);
    idle(4'h8);

    // Reset after 5 beats, release with prog_mode high, reload from 0.
    cycle(1, 1, 0, 8'h00, 0, 4'h0, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1, 1, 1, 8'(8'hB0 + i), 0, 4'h4, 8'h00);
    repeat (2) cycle(0, 1, 1, 8'hDD, 0, 4'h0, 8'h00);
    cycle(1, 1, 1, 8'hDD, 0, 4'h0, 8'h00);
    for (int i = 0; i < 4; i++) cycle(1, 1, 1, 8'(8'hC0 + i), 0, 4'h0, 8'h00);
    idle(4'h0);
    idle(4'h4);
    idle(4'h5);

    // Randomized traffic: slow prog_mode toggles, occasional resets.
    pm = 0;
    for (int i = 0; i < 800; i++) begin
      k  = int'($urandom_range(0, 149));
      rn = (k != 0);
      if ($urandom_range(0, 39) == 0) pm = !pm;
      we = rn && ($urandom_range(0, 3) == 0);
      cycle(rn, pm, $urandom_range(0, 2) != 0, 8'($urandom), we, 4'($urandom), 8'($urandom));
    end
    idle(4'h0);

    repeat (2) @(posedge clk);
    #2;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
